// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - request/response bundle between M-stage initiator and data memory
// Purpose: groups the data-side request, stall and response signals.
// Signals:
//   req_en     initiator -> memory  access request, held while stall=1
//   req_wen    initiator -> memory  byte write enables (4'b0000 = read)
//   req_addr   initiator -> memory  byte address
//   req_wdata  initiator -> memory  lane-replicated store data
//   rdata      memory -> initiator  registered read word
//   stall      memory -> initiator  data-side stall
//   resp_valid memory -> initiator  one-cycle completion pulse
interface dmem_responder_if;
    logic        req_en;
    logic [3:0]  req_wen;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] rdata;
    logic        stall;
    logic        resp_valid;

    modport master (
        output req_en, req_wen, req_addr, req_wdata,
        input  rdata, stall, resp_valid
    );

    modport slave (
        input  req_en, req_wen, req_addr, req_wdata,
        output rdata, stall, resp_valid
    );
endinterface

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data memory responder with optional wait states
// Purpose: word-organised data RAM answering M-stage loads/stores with a
//   stall/resp_valid handshake. Optional macro DMEM_WAIT_EN inserts a WAIT
//   state with a WAIT_CYCLES down-counter; without it each access stalls one cycle.
// Parameters:
//   DEPTH_LOG2  log2 of RAM word count
//   WAIT_CYCLES extra wait states (0..15), only meaningful with DMEM_WAIT_EN
// Ports:
//   clk  clock, rising edge
//   rst  asynchronous active-low reset
//   bus  dmem_responder_if.slave (request in, rdata/stall/resp_valid out)
module dmem_responder #(
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    dmem_responder_if.slave   bus
);
    localparam int WORDS = 1 << DEPTH_LOG2;

    logic [31:0]           mem [WORDS];
    logic [DEPTH_LOG2-1:0] index;
    logic [31:0]           rdata_q;
    logic                  resp_valid_q;
    logic                  is_read;
    logic                  do_access;
    logic                  stall_c;

    // High address bits and byte offset are ignored; index wraps naturally.
    assign index   = bus.req_addr[DEPTH_LOG2+1:2];
    assign is_read = (bus.req_wen == 4'b0000);

`ifdef DMEM_WAIT_EN
    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
    state_t     state;
    logic [3:0] count;

    assign do_access = (state == WAIT) && (count == 4'd0) && bus.req_en;
    // Dropping req_en in WAIT is a flush: stall releases in the same cycle.
    assign stall_c   = rst && bus.req_en && ((state == IDLE) || (state == WAIT));
`else
    typedef enum logic {IDLE, DONE} state_t;
    state_t state;

    assign do_access = (state == IDLE) && bus.req_en;
    assign stall_c   = rst && bus.req_en && (state == IDLE);
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            rdata_q      <= 32'h0;
            resp_valid_q <= 1'b0;
`ifdef DMEM_WAIT_EN
            count        <= 4'd0;
`endif
        end else begin
            resp_valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req_en) begin
`ifdef DMEM_WAIT_EN
                        state <= WAIT;
                        count <= 4'(WAIT_CYCLES);
`else
                        state        <= DONE;
                        resp_valid_q <= 1'b1;
                        if (is_read) rdata_q <= mem[index];
`endif
                    end
                end
`ifdef DMEM_WAIT_EN
                WAIT: begin
                    if (!bus.req_en) begin
                        state <= IDLE;
                        count <= 4'd0;
                    end else if (count != 4'd0) begin
                        count <= count - 4'd1;
                    end else begin
                        state        <= DONE;
                        resp_valid_q <= 1'b1;
                        if (is_read) rdata_q <= mem[index];
                    end
                end
`endif
                // req_en seen here belongs to the retiring access.
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // RAM has no reset; the rst term drops a write whose edge coincides with reset.
    always_ff @(posedge clk) begin
        if (rst && do_access) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.req_wen[i]) mem[index][8*i +: 8] <= bus.req_wdata[8*i +: 8];
            end
        end
    end

    assign bus.rdata      = rdata_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.stall      = stall_c;

    logic unused_bits;
`ifdef DMEM_WAIT_EN
    assign unused_bits = &{1'b0, bus.req_addr[31:DEPTH_LOG2+2], bus.req_addr[1:0]};
`else
    logic [3:0] unused_wait;
    assign unused_wait = 4'(WAIT_CYCLES);
    assign unused_bits = &{1'b0, bus.req_addr[31:DEPTH_LOG2+2], bus.req_addr[1:0], unused_wait};
`endif
endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - self-checking bench for dmem_responder
module tb_dmem_responder;
    localparam int DL    = 10;
    localparam int WC    = 2;
    localparam int WORDS = 1 << DL;
`ifdef DMEM_WAIT_EN
    localparam int STALL_LEN = WC + 2;
`else
    localparam int STALL_LEN = 1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errors = 0;
    int   checks = 0;

    logic [31:0] model [int];
    logic [31:0] last_rdata = 32'h0;

    dmem_responder_if bus ();

    dmem_responder #(.DEPTH_LOG2(DL), .WAIT_CYCLES(WC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // req_wen must not move while the access is stalled.
    logic [3:0] prev_wen   = 4'h0;
    logic       prev_stall = 1'b0;
    always @(negedge clk) begin
        if (bus.stall && prev_stall) check("wen_stable", 32'(bus.req_wen), 32'(prev_wen));
        prev_stall = bus.stall;
        prev_wen   = bus.req_wen;
    end

    // Full access: checks stall for every stalled cycle, then the completion cycle.
    task automatic access(input string tag, input logic [3:0] wen, input logic [31:0] addr,
                          input logic [31:0] wdata);
        int          idx;
        logic [31:0] cur;
        idx = int'(addr[DL+1:2]);
        bus.req_en    = 1'b1;
        bus.req_wen   = wen;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        for (int c = 0; c < STALL_LEN; c++) begin
            @(negedge clk);
            check({tag, " stall"}, 32'(bus.stall), 32'd1);
            check({tag, " early_valid"}, 32'(bus.resp_valid), 32'd0);
            @(posedge clk); #1;
        end
        cur = model.exists(idx) ? model[idx] : 32'h0;
        if (wen == 4'b0000) begin
            last_rdata = cur;
        end else begin
            for (int i = 0; i < 4; i++)
                if (wen[i]) cur[8*i +: 8] = wdata[8*i +: 8];
            model[idx] = cur;
        end
        @(negedge clk);
        check({tag, " done_stall"}, 32'(bus.stall), 32'd0);
        check({tag, " resp_valid"}, 32'(bus.resp_valid), 32'd1);
        check({tag, " rdata"}, bus.rdata, last_rdata);
        @(posedge clk); #1;
        bus.req_en = 1'b0;
    endtask

    task automatic idle_cycle(input string tag);
        bus.req_en = 1'b0;
        @(negedge clk);
        check({tag, " idle_stall"}, 32'(bus.stall), 32'd0);
        check({tag, " idle_valid"}, 32'(bus.resp_valid), 32'd0);
        @(posedge clk); #1;
    endtask

    int          picks [8] = '{0, 1, 2, 7, 64, 511, 512, 1023};
    logic [31:0] raddr;
    logic [3:0]  rwen;

    initial begin
        bus.req_en    = 1'b1;
        bus.req_wen   = 4'h0;
        bus.req_addr  = 32'h0;
        bus.req_wdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_stall", 32'(bus.stall), 32'd0);
        check("reset_valid", 32'(bus.resp_valid), 32'd0);
        check("reset_rdata", bus.rdata, 32'h0);
        bus.req_en = 1'b0;
        rst = 1'b1;
        idle_cycle("post_reset");

        access("wr_deadbeef", 4'hF, 32'h10, 32'hDEADBEEF);
        access("rd_deadbeef", 4'h0, 32'h10, 32'h0);
        check("deadbeef_value", bus.rdata, 32'hDEADBEEF);

        access("wr_full", 4'hF, 32'h10, 32'h11223344);
        access("wr_byte1", 4'b0010, 32'h10, 32'hAAAAAAAA);
        access("rd_byte1", 4'h0, 32'h10, 32'h0);
        check("byte_merge", bus.rdata, 32'h1122AA44);

        access("wr_wrap", 4'hF, 32'h1000, 32'h5A5A5A5A);
        access("rd_wrap", 4'h0, 32'h0, 32'h0);
        check("wrap_value", bus.rdata, 32'h5A5A5A5A);
        idle_cycle("after_wrap");

`ifdef DMEM_WAIT_EN
        // Flush in WAIT cycle 2 of a read.
        bus.req_en = 1'b1; bus.req_wen = 4'h0; bus.req_addr = 32'h0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.req_en = 1'b0;
        #1;
        check("abort_stall", 32'(bus.stall), 32'd0);
        check("abort_valid", 32'(bus.resp_valid), 32'd0);
        @(posedge clk); #1;
        check("abort_valid_next", 32'(bus.resp_valid), 32'd0);
        check("abort_rdata", bus.rdata, last_rdata);
        idle_cycle("abort_idle");
        access("after_abort", 4'h0, 32'h10, 32'h0);
`endif

        // Async reset in the middle of a write; the target word must survive.
        access("rst_prep", 4'hF, 32'hC, 32'h01020304);
        bus.req_en = 1'b1; bus.req_wen = 4'hF; bus.req_addr = 32'hC; bus.req_wdata = 32'hFFFFFFFF;
`ifdef DMEM_WAIT_EN
        @(posedge clk); #1;
`endif
        #2;
        rst = 1'b0;
        #1;
        check("midrst_stall", 32'(bus.stall), 32'd0);
        check("midrst_valid", 32'(bus.resp_valid), 32'd0);
        check("midrst_rdata", bus.rdata, 32'h0);
        last_rdata = 32'h0;
        bus.req_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        idle_cycle("rst_release");
        access("rst_readback", 4'h0, 32'hC, 32'h0);
        check("rst_word_kept", bus.rdata, 32'h01020304);

        // Back-to-back reads.
        access("b2b_0", 4'h0, 32'h10, 32'h0);
        access("b2b_1", 4'h0, 32'h0, 32'h0);
        access("b2b_2", 4'h0, 32'hC, 32'h0);

        // Randomised traffic over a handful of words with random alias bits.
        foreach (picks[k]) begin
            raddr = ($urandom() & 32'hFFFF_F000) | (32'(picks[k]) << 2) | 32'($urandom_range(0, 3));
            access("rnd_init", 4'hF, raddr, $urandom());
        end
        for (int n = 0; n < 40; n++) begin
            raddr = ($urandom() & 32'hFFFF_F000) | (32'(picks[$urandom_range(0, 7)]) << 2)
                    | 32'($urandom_range(0, 3));
            rwen  = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            access("rnd", rwen, raddr, $urandom());
            if ($urandom_range(0, 3) == 0) idle_cycle("rnd_gap");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
